// File: rtl/addr_gen_wr_hc.sv
// Write address generator for the H/C state memories: zero-fills the t=-1 slot,
// then issues one write per accepted result beat per channel.
module addr_gen_wr_hc #(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMESTEP   = 7,
  parameter int NUM_CELL   = 53
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  i_valid_c,
  input  logic                  i_valid_h,
  output logic                  o_ready,
  output logic                  o_we_c,
  output logic                  o_we_h,
  output logic [ADDR_WIDTH-1:0] o_addr_c,
  output logic [ADDR_WIDTH-1:0] o_addr_h,
  output logic                  o_zero,
  output logic                  o_step_done,
  output logic                  o_done,
  output logic                  o_err
);
  localparam int LAST = NUM_CELL * (TIMESTEP + 1) - 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(LAST);
  localparam logic [ADDR_WIDTH-1:0] END_A  = ADDR_WIDTH'(LAST + 1);
  localparam logic [ADDR_WIDTH-1:0] NC_A   = ADDR_WIDTH'(NUM_CELL);
  localparam logic [ADDR_WIDTH-1:0] NC1_A  = ADDR_WIDTH'(NUM_CELL - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] zcnt, zcnt_d, cnt_c, cnt_c_d, cnt_h, cnt_h_d, hcell, hcell_d;
  logic [ADDR_WIDTH-1:0] addr_c_d, addr_h_d;
  logic                  we_c_d, we_h_d, zero_d, step_d, ready_d, done_d, err_d;
  logic                  acc_c, acc_h;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      zcnt        <= '0;
      cnt_c       <= '0;
      cnt_h       <= '0;
      hcell       <= '0;
      o_we_c      <= 1'b0;
      o_we_h      <= 1'b0;
      o_addr_c    <= '0;
      o_addr_h    <= '0;
      o_zero      <= 1'b0;
      o_step_done <= 1'b0;
      o_ready     <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_d;
      zcnt        <= zcnt_d;
      cnt_c       <= cnt_c_d;
      cnt_h       <= cnt_h_d;
      hcell       <= hcell_d;
      o_we_c      <= we_c_d;
      o_we_h      <= we_h_d;
      o_addr_c    <= addr_c_d;
      o_addr_h    <= addr_h_d;
      o_zero      <= zero_d;
      o_step_done <= step_d;
      o_ready     <= ready_d;
      o_done      <= done_d;
      o_err       <= err_d;
    end
  end

  always_comb begin
    state_d  = state;
    zcnt_d   = zcnt;
    cnt_c_d  = cnt_c;
    cnt_h_d  = cnt_h;
    hcell_d  = hcell;
    we_c_d   = 1'b0;
    we_h_d   = 1'b0;
    addr_c_d = o_addr_c;
    addr_h_d = o_addr_h;
    zero_d   = 1'b0;
    step_d   = 1'b0;
    ready_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = o_err;
    acc_c    = 1'b0;
    acc_h    = 1'b0;
    case (state)
      IDLE: begin
        addr_c_d = '0;
        addr_h_d = '0;
        if (en) begin
          state_d = INIT;
          zcnt_d  = '0;
        end
      end
      INIT: begin
        we_c_d   = 1'b1;
        we_h_d   = 1'b1;
        zero_d   = 1'b1;
        addr_c_d = zcnt;
        addr_h_d = zcnt;
        zcnt_d   = zcnt + ONE;
        if (i_valid_c || i_valid_h) err_d = 1'b1;
        if (zcnt == NC1_A) begin
          state_d = RUN;
          cnt_c_d = NC_A;
          cnt_h_d = NC_A;
          hcell_d = '0;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        ready_d = 1'b1;
        acc_c   = i_valid_c && (cnt_c <= LAST_A);
        // H may only write a slot whose C write has been (or is being) accepted
        acc_h   = i_valid_h && (cnt_h <= LAST_A) &&
                  ({1'b0, cnt_h} < ({1'b0, cnt_c} + {{ADDR_WIDTH{1'b0}}, acc_c}));
        if (i_valid_c && !acc_c) err_d = 1'b1;
        if (i_valid_h && !acc_h) err_d = 1'b1;
        if (acc_c) begin
          we_c_d   = 1'b1;
          addr_c_d = cnt_c;
          cnt_c_d  = cnt_c + ONE;
        end
        if (acc_h) begin
          we_h_d   = 1'b1;
          addr_h_d = cnt_h;
          cnt_h_d  = cnt_h + ONE;
          step_d   = (hcell == NC1_A);
          hcell_d  = (hcell == NC1_A) ? '0 : hcell + ONE;
        end
        if (cnt_c_d == END_A && cnt_h_d == END_A) begin
          state_d = DONE;
          ready_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        done_d = 1'b1;
        if (i_valid_c || i_valid_h) err_d = 1'b1;
        if (!en) begin
          state_d  = IDLE;
          done_d   = 1'b0;
          addr_c_d = '0;
          addr_h_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_addr_gen_wr_hc.sv
// Directed bench for addr_gen_wr_hc: init sweep, full pass, protocol errors, resets.
module tb_addr_gen_wr_hc;
  logic        clk = 1'b0;
  logic        rst, en, i_valid_c, i_valid_h;
  logic        o_ready, o_we_c, o_we_h, o_zero, o_step_done, o_done, o_err;
  logic [11:0] o_addr_c, o_addr_h;
  int          checks = 0;
  int          errors = 0;

  addr_gen_wr_hc dut (
    .clk(clk), .rst(rst), .en(en), .i_valid_c(i_valid_c), .i_valid_h(i_valid_h),
    .o_ready(o_ready), .o_we_c(o_we_c), .o_we_h(o_we_h),
    .o_addr_c(o_addr_c), .o_addr_h(o_addr_h), .o_zero(o_zero),
    .o_step_done(o_step_done), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we_c"}, {31'd0, o_we_c}, 0);
    chk({tag, "_we_h"}, {31'd0, o_we_h}, 0);
    chk({tag, "_addr_c"}, {20'd0, o_addr_c}, 0);
    chk({tag, "_addr_h"}, {20'd0, o_addr_h}, 0);
    chk({tag, "_zero"}, {31'd0, o_zero}, 0);
    chk({tag, "_step"}, {31'd0, o_step_done}, 0);
    chk({tag, "_ready"}, {31'd0, o_ready}, 0);
    chk({tag, "_done"}, {31'd0, o_done}, 0);
    chk({tag, "_err"}, {31'd0, o_err}, 0);
  endtask

  initial begin
    int   exp_c, exp_h, steps, nc;
    logic pvc, pvh, first, inj, err_next;
    logic [2:0] dl;

    rst = 1'b1; en = 1'b0; i_valid_c = 1'b0; i_valid_h = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // async reset in the middle of INIT with en held high
    en = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("rst_init");
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("idle");

    // init sweep
    en = 1'b1;
    @(negedge clk);
    chk("init_lat_we", {31'd0, o_we_c}, 0);
    for (int i = 0; i < 53; i++) begin
      @(negedge clk);
      chk("init_we_c", {31'd0, o_we_c}, 1);
      chk("init_we_h", {31'd0, o_we_h}, 1);
      chk("init_zero", {31'd0, o_zero}, 1);
      chk("init_addr_c", {20'd0, o_addr_c}, i);
      chk("init_addr_h", {20'd0, o_addr_h}, i);
      chk("init_ready", {31'd0, o_ready}, (i == 52) ? 1 : 0);
    end

    // full pass: first beat simultaneous on both channels, then H lags C by 3 cycles
    exp_c = 53; exp_h = 53; steps = 0; nc = 1;
    first = 1'b1; inj = 1'b0; err_next = 1'b0; dl = 3'b000;
    i_valid_c = 1'b1; i_valid_h = 1'b1; pvc = 1'b1; pvh = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      chk("run_we_c", {31'd0, o_we_c}, {31'd0, pvc});
      chk("run_we_h", {31'd0, o_we_h}, {31'd0, pvh});
      if (o_we_c) begin
        chk("run_addr_c", {20'd0, o_addr_c}, exp_c);
        chk("run_zero", {31'd0, o_zero}, 0);
        exp_c++;
      end
      if (o_we_h) begin
        chk("run_addr_h", {20'd0, o_addr_h}, exp_h);
        chk("run_step", {31'd0, o_step_done}, ((exp_h + 1) % 53 == 0) ? 1 : 0);
        if (o_step_done) steps++;
        exp_h++;
      end else begin
        chk("run_step_idle", {31'd0, o_step_done}, 0);
      end
      if (first) begin
        chk("simul_addr_c", {20'd0, o_addr_c}, 53);
        chk("simul_addr_h", {20'd0, o_addr_h}, 53);
        first = 1'b0;
      end
      if (err_next) begin
        chk("err_c_over", {31'd0, o_err}, 1);
        err_next = 1'b0;
      end
      if (o_done) break;
      if (nc == 371 && !inj) begin
        chk("err_clean_pass", {31'd0, o_err}, 0);
        i_valid_c = 1'b1; pvc = 1'b0; inj = 1'b1; err_next = 1'b1;
        dl = {dl[1:0], 1'b0};
      end else begin
        i_valid_c = (nc < 371) && ($urandom_range(3, 0) != 0);
        if (i_valid_c) nc++;
        pvc = i_valid_c;
        i_valid_h = dl[2];
        pvh = dl[2];
        dl = {dl[1:0], i_valid_c};
        continue;
      end
      i_valid_h = dl[2];
      pvh = dl[2];
    end
    i_valid_c = 1'b0; i_valid_h = 1'b0;
    chk("pass_done", {31'd0, o_done}, 1);
    chk("pass_ready", {31'd0, o_ready}, 0);
    chk("pass_cnt_c", exp_c, 424);
    chk("pass_cnt_h", exp_h, 424);
    chk("pass_steps", steps, 7);
    chk("pass_err", {31'd0, o_err}, 1);

    // DONE -> IDLE
    en = 1'b0;
    @(negedge clk);
    chk("done_clear", {31'd0, o_done}, 0);
    chk("err_sticky_idle", {31'd0, o_err}, 1);

    rst = 1'b1;
    #1 chk("err_rst", {31'd0, o_err}, 0);
    @(negedge clk);
    rst = 1'b0;

    // H without an outstanding C write
    en = 1'b1;
    for (int k = 0; k < 100 && !o_ready; k++) @(negedge clk);
    chk("ready_wait", {31'd0, o_ready}, 1);
    i_valid_h = 1'b1;
    @(negedge clk);
    i_valid_h = 1'b0;
    chk("h_ahead_we", {31'd0, o_we_h}, 0);
    chk("h_ahead_err", {31'd0, o_err}, 1);

    // 100 C writes then reset mid-RUN
    i_valid_c = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("c100_we", {31'd0, o_we_c}, 1);
      chk("c100_addr", {20'd0, o_addr_c}, 53 + i);
    end
    i_valid_c = 1'b0;
    chk("c100_err_sticky", {31'd0, o_err}, 1);
    #2 rst = 1'b1;
    #1 chk_zero("rst_run");
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // fresh sweep from address 0, with a valid injected during INIT
    en = 1'b1;
    @(negedge clk);
    chk("re_init_lat", {31'd0, o_we_c}, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("re_init_addr", {20'd0, o_addr_c}, i);
      chk("re_init_zero", {31'd0, o_zero}, 1);
      chk("init_valid_err", {31'd0, o_err}, (i >= 5) ? 1 : 0);
      i_valid_c = (i == 4);
    end
    i_valid_c = 1'b0;
    repeat (5) @(negedge clk);
    chk("err_hold", {31'd0, o_err}, 1);
    rst = 1'b1;
    #1 chk("err_final_rst", {31'd0, o_err}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/addr_gen_wr_hc.md
Name: addr_gen_wr_hc

Overview:
Write address generator for the H and C state memories during forward propagation. On start it zero-fills the t = -1 slot, addresses 0 .. NUM_CELL-1. It then issues one write address and one write enable per result beat from the cell compute pipeline, separately for C and H, from address NUM_CELL up to NUM_CELL*(TIMESTEP+1)-1. It is the writer that fills the memories the forward read address generator consumes.

Parameters:
ADDR_WIDTH, 12, width of both address outputs and internal counters
TIMESTEP, 7, number of timesteps written (excluding the t = -1 zero slot)
NUM_CELL, 53, cells per timestep, i.e. results per timestep per channel

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
en  input  1  start/hold; a rising level in IDLE starts a pass, deassertion in DONE returns to IDLE
i_valid_c  input  1  one C result is available this cycle
i_valid_h  input  1  one H result is available this cycle
o_ready  output  1  high in RUN only; the compute pipeline may issue valids
o_we_c  output  1  C memory write enable
o_we_h  output  1  H memory write enable
o_addr_c  output  ADDR_WIDTH  C memory write address
o_addr_h  output  ADDR_WIDTH  H memory write address
o_zero  output  1  write-data select: 1 = write zero (init sweep), 0 = pipeline data
o_step_done  output  1  one-cycle pulse with the H write of the last cell of each timestep
o_done  output  1  level, high in DONE
o_err  output  1  sticky protocol error flag, cleared only by rst

Behaviour:
- Reset: clk and rst as stated; rst is asynchronous and active-high. Every output, counter and the state return to 0 / IDLE immediately. Reset mid-pass aborts the pass; no completion is reported.
- All outputs are registered. Write enable and address appear 1 cycle after the causing input or state.
- IDLE: all outputs 0 except the held o_err. en = 1 -> INIT; zcnt <= 0.
- INIT, NUM_CELL cycles:
  - o_we_c = o_we_h = 1, o_zero = 1, o_addr_c = o_addr_h = zcnt; zcnt increments 0 .. NUM_CELL-1.
  - After the write of NUM_CELL-1 -> RUN; cnt_c = cnt_h = NUM_CELL, o_ready = 1 from the first RUN cycle.
  - Any i_valid_c or i_valid_h during INIT sets o_err; that beat is dropped.
- RUN, C channel:
  - If i_valid_c and cnt_c <= LAST (LAST = NUM_CELL*(TIMESTEP+1)-1): next cycle o_we_c = 1, o_addr_c = cnt_c, o_zero = 0; cnt_c increments.
  - Otherwise o_we_c = 0. o_addr_c holds its last value.
  - i_valid_c after cnt_c has passed LAST sets o_err; no write.
- RUN, H channel:
  - Same rule with i_valid_h and cnt_h.
  - H must not overtake C. A valid_h is accepted only if cnt_h < cnt_c + (accepted i_valid_c in the same cycle ? 1 : 0).
  - Otherwise o_err is set and the beat is dropped.
  - The two channels are independent and may both write in the same cycle.
- o_step_done: asserted together with o_we_h when the accepted H address satisfies (addr+1) mod NUM_CELL == 0, addr >= NUM_CELL. TIMESTEP pulses per pass.
- RUN -> DONE once both channels have written LAST; this may be on the same cycle. o_ready drops in the cycle DONE is entered.
- DONE: o_done = 1, no writes; valids set o_err. en = 0 -> IDLE; o_done clears next cycle.
- en dropping in INIT or RUN is ignored; the pass runs to completion.
- Width rule: NUM_CELL*(TIMESTEP+1) must be < 2^ADDR_WIDTH; counters never wrap.

Test Plan:
- Reset values: assert rst mid-clock with en = 1 -> all outputs 0 asynchronously, state IDLE; after release with en = 0 the outputs stay 0.
- Init sweep: en = 1 -> from the following cycle 53 cycles of o_we_c = o_we_h = o_zero = 1, addresses 0..52 in order, then o_ready = 1.
- Full pass with defaults: 371 valid_c beats, with valid_h lagging 3 cycles and random idle gaps -> C writes addresses 53..423 in order, H writes the same sequence, 7 o_step_done pulses at H addresses 105, 158, ..., 423, then o_done = 1. en = 0 -> IDLE.
- Simultaneous valids: valid_c and valid_h on the same cycle with cnt_h == cnt_c -> both accepted, o_addr_c == o_addr_h next cycle, o_err stays 0.
- Errors:
  - valid_h with no outstanding C write -> o_err = 1, no o_we_h.
  - 372nd valid_c -> o_err = 1, no o_we_c.
  - valid during INIT -> o_err = 1.
  - o_err then stays set until rst.
- Reset mid-RUN after 100 C writes -> outputs 0 immediately; a fresh en repeats the INIT sweep from address 0.
